// File: rtl/simt_stack_unit.sv
// -----------------------------------------------------------------------------
// simt_stack_unit
//
// Per-core SIMT reconvergence stack. The datapath pushes divergence entries
// ({sync PC, resume PC, thread mask}) and pops them at sync points. The top of
// the stack drives the current* outputs, which gate lane writeback and select
// the next PC at reconvergence.
//
// Parameters
//   THREADS  lanes per core (width of every mask)
//   DEPTH    number of stack entries (power of 2, >= 2)
//   CPUID    core index, used only in assertion messages
//
// Ports
//   CLK          in   core clock, all state updates on the rising edge
//   nRST         in   asynchronous active-low reset
//   pushEn[1:0]  in   00 idle, 01 push, 10 diverge-push, 11 treated as push
//   popEn        in   pop the top entry
//   newSync      in   reconvergence PC of the pushed entry
//   newAddr      in   resume PC of the pushed entry
//   newMask      in   active mask of the pushed entry
//   currentSync  out  top-entry sync PC   (0 when empty)
//   currentAddr  out  top-entry resume PC (0 when empty)
//   currentMask  out  top-entry mask      (all ones when empty)
//   overflow     out  push rejected because the stack was full
//   underflow    out  pop rejected because the stack was empty
//   isEmpty      out  no entries held
//
// Configuration macro
//   SIMT_STACK_STICKY_ERR_EN  when defined, overflow/underflow stay set until
//                             reset; otherwise they are one-cycle pulses.
// -----------------------------------------------------------------------------
module simt_stack_unit #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 8,
  parameter int CPUID   = 0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [1:0]         pushEn,
  input  logic               popEn,
  input  logic [31:0]        newSync,
  input  logic [31:0]        newAddr,
  input  logic [THREADS-1:0] newMask,
  output logic [31:0]        currentSync,
  output logic [31:0]        currentAddr,
  output logic [THREADS-1:0] currentMask,
  output logic               overflow,
  output logic               underflow,
  output logic               isEmpty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [31:0]        sync_pc;
    logic [31:0]        resume_pc;
    logic [THREADS-1:0] mask;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             stack_q [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic               push_req;
  logic               div_req;
  logic               empty;
  logic               full;
  logic [IDX_W-1:0]   top_idx;
  entry_t             new_entry;

  assign push_req  = |pushEn;
  // Encoding 11 is reserved and behaves like a plain push.
  assign div_req   = (pushEn == 2'b10);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // Only meaningful when not empty; the wrap at count 0 is masked by 'empty'.
  assign top_idx   = IDX_W'(count_q - CNT_W'(1));
  assign new_entry = '{sync_pc: newSync, resume_pc: newAddr, mask: newMask};

  // ---------------------------------------------------------------------------
  // Next-state / write-enable generation
  // ---------------------------------------------------------------------------
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic               edit_en;
  logic               ovf_hit;
  logic               unf_hit;

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    edit_en = 1'b0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;

    if (popEn) begin
      if (empty) begin
        // Nothing to pop; a paired push is dropped along with it.
        unf_hit = 1'b1;
      end else if (push_req) begin
        // Pop+push replaces the top in place. The divergence mask edit is
        // skipped because the entry it would modify is being overwritten.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end else if (push_req) begin
      if (full) begin
        ovf_hit = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(count_q);
        count_d = count_q + CNT_W'(1);
        // With an empty stack there is no top to edit: plain push.
        edit_en = div_req && !empty;
      end
    end

`ifdef SIMT_STACK_STICKY_ERR_EN
    ovf_d = ovf_q | ovf_hit;
    unf_d = unf_q | unf_hit;
`else
    ovf_d = ovf_hit;
    unf_d = unf_hit;
`endif
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset; contents above count_q are never
  // observed, so resetting them would only add logic.
  always_ff @(posedge CLK) begin
    // Divergence: strip the lanes taken by the new path from the current top.
    // The edit targets count-1 and the push targets count, so they never clash.
    if (edit_en) begin
      stack_q[top_idx].mask <= stack_q[top_idx].mask & ~newMask;
    end
    if (wr_en) begin
      stack_q[wr_idx] <= new_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (zero-latency read of the top entry)
  // ---------------------------------------------------------------------------
  assign isEmpty     = empty;
  assign currentSync = empty ? 32'd0 : stack_q[top_idx].sync_pc;
  assign currentAddr = empty ? 32'd0 : stack_q[top_idx].resume_pc;
  // An empty stack means no divergence is pending: every lane is live.
  assign currentMask = empty ? {THREADS{1'b1}} : stack_q[top_idx].mask;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  a_count_range: assert property (@(posedge CLK) disable iff (!nRST)
    count_q <= CNT_W'(DEPTH))
    else $error("simt_stack_unit core %0d: count out of range", CPUID);

endmodule

// File: tb/tb_simt_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_simt_stack_unit
//
// Self-checking bench for simt_stack_unit. A queue-based reference model
// tracks the expected stack contents and error flags; directed sequences cover
// the documented scenarios and a randomized phase exercises mixed traffic.
// Honors SIMT_STACK_STICKY_ERR_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_simt_stack_unit;

  localparam int THREADS = 4;
  localparam int DEPTH   = 8;

  typedef struct {
    logic [31:0]        s;
    logic [31:0]        a;
    logic [THREADS-1:0] m;
  } ent_t;

  logic               CLK;
  logic               nRST;
  logic [1:0]         pushEn;
  logic               popEn;
  logic [31:0]        newSync;
  logic [31:0]        newAddr;
  logic [THREADS-1:0] newMask;
  logic [31:0]        currentSync;
  logic [31:0]        currentAddr;
  logic [THREADS-1:0] currentMask;
  logic               overflow;
  logic               underflow;
  logic               isEmpty;

  simt_stack_unit #(.THREADS(THREADS), .DEPTH(DEPTH), .CPUID(0)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .pushEn      (pushEn),
    .popEn       (popEn),
    .newSync     (newSync),
    .newAddr     (newAddr),
    .newMask     (newMask),
    .currentSync (currentSync),
    .currentAddr (currentAddr),
    .currentMask (currentMask),
    .overflow    (overflow),
    .underflow   (underflow),
    .isEmpty     (isEmpty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  ent_t ref_q[$];
  bit   exp_ovf;
  bit   exp_unf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  // Applies one cycle's worth of operation to the reference model.
  task automatic model_step(input logic [1:0] pe, input logic pop,
                            input logic [31:0] s, input logic [31:0] a,
                            input logic [THREADS-1:0] m);
    bit push = (pe != 2'b00);
    bit div  = (pe == 2'b10);
    bit ovf  = 1'b0;
    bit unf  = 1'b0;
    ent_t e;
    e.s = s; e.a = a; e.m = m;
    if (pop) begin
      if (ref_q.size() == 0)       unf = 1'b1;
      else if (push)               ref_q[ref_q.size()-1] = e;
      else                         void'(ref_q.pop_back());
    end else if (push) begin
      if (ref_q.size() == DEPTH) ovf = 1'b1;
      else begin
        if (div && ref_q.size() > 0)
          ref_q[ref_q.size()-1].m = ref_q[ref_q.size()-1].m & ~m;
        ref_q.push_back(e);
      end
    end
`ifdef SIMT_STACK_STICKY_ERR_EN
    exp_ovf = exp_ovf | ovf;
    exp_unf = exp_unf | unf;
`else
    exp_ovf = ovf;
    exp_unf = unf;
`endif
  endtask

  task automatic check_all(input string tag);
    logic [31:0]        es = 32'd0;
    logic [31:0]        ea = 32'd0;
    logic [THREADS-1:0] em = '1;
    if (ref_q.size() > 0) begin
      es = ref_q[ref_q.size()-1].s;
      ea = ref_q[ref_q.size()-1].a;
      em = ref_q[ref_q.size()-1].m;
    end
    check({tag, ".sync"},  currentSync, es);
    check({tag, ".addr"},  currentAddr, ea);
    check({tag, ".mask"},  32'(currentMask), 32'(em));
    check({tag, ".empty"}, 32'(isEmpty),   32'(ref_q.size() == 0));
    check({tag, ".ovf"},   32'(overflow),  32'(exp_ovf));
    check({tag, ".unf"},   32'(underflow), 32'(exp_unf));
  endtask

  // Drive one operation for one clock, update the model, check at negedge.
  task automatic op(input string tag, input logic [1:0] pe, input logic pop,
                    input logic [31:0] s, input logic [31:0] a,
                    input logic [THREADS-1:0] m);
    pushEn = pe; popEn = pop; newSync = s; newAddr = a; newMask = m;
    @(posedge CLK);
    model_step(pe, pop, s, a, m);
    @(negedge CLK);
    pushEn = 2'b00; popEn = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; pushEn = 2'b00; popEn = 1'b0;
    newSync = '0; newAddr = '0; newMask = '0;
    model_reset();
    #1;
    check_all("reset_async");
    do_reset();
    op("idle", 2'b00, 1'b0, 0, 0, 0);
    check("idle.empty_const", 32'(isEmpty), 32'd1);
    check("idle.mask_const",  32'(currentMask), 32'hF);

    // Basic push
    op("push1", 2'b01, 1'b0, 32'h40, 32'h20, 4'b0011);
    check("push1.sync_const", currentSync, 32'h40);
    check("push1.mask_const", 32'(currentMask), 32'h3);

    // Divergence edit then pop reveals edited mask
    do_reset();
    op("top1111", 2'b01, 1'b0, 32'h100, 32'h80, 4'b1111);
    op("div0101", 2'b10, 1'b0, 32'h100, 32'h90, 4'b0101);
    check("div.mask_const", 32'(currentMask), 32'h5);
    op("div_pop", 2'b00, 1'b1, 0, 0, 0);
    check("div_pop.mask_const", 32'(currentMask), 32'hA);
    // Diverge-push on empty stack acts as plain push
    do_reset();
    op("div_empty", 2'b10, 1'b0, 32'h7, 32'h8, 4'b0110);
    // Reserved encoding behaves as push
    op("push11", 2'b11, 1'b0, 32'h9, 32'hA, 4'b1001);
    // Pop+diverge-push: top replaced, no mask edit below
    op("pop_div", 2'b10, 1'b1, 32'hB, 32'hC, 4'b0010);
    op("pop_below", 2'b00, 1'b1, 0, 0, 0);

    // Fill, overflow, replace at full
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      op("fill", 2'b01, 1'b0, 32'h1000 + i, 32'h2000 + i, 4'(i + 1));
    op("ovf", 2'b01, 1'b0, 32'hDEAD, 32'hBEEF, 4'b1010);
    check("ovf.flag_const", 32'(overflow), 32'd1);
    check("ovf.top_const", currentSync, 32'h1007);
    op("ovf_after", 2'b00, 1'b0, 0, 0, 0);
    op("full_replace", 2'b01, 1'b1, 32'h5555, 32'h6666, 4'b0100);
    check("full_replace.sync_const", currentSync, 32'h5555);

    // Underflow on empty, including pop paired with push
    do_reset();
    op("unf", 2'b00, 1'b1, 0, 0, 0);
    check("unf.flag_const", 32'(underflow), 32'd1);
    op("unf_after", 2'b00, 1'b0, 0, 0, 0);
    op("unf_push", 2'b01, 1'b1, 32'h1, 32'h2, 4'b0001);

    // Reset mid-operation with 3 entries held
    do_reset();
    for (int i = 0; i < 3; i++)
      op("pre_rst", 2'b01, 1'b0, 32'h300 + i, 32'h400 + i, 4'b0111);
    pushEn = 2'b01; newSync = 32'hFFFF; newAddr = 32'hEEEE; newMask = 4'b0001;
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge CLK);
    pushEn = 2'b00;
    nRST = 1'b1;
    op("post_rst", 2'b00, 1'b0, 0, 0, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      logic [1:0] pe;
      logic       pp;
      if (n % 150 == 149) do_reset();
      pe = (r < 45) ? 2'($urandom_range(1, 3)) : 2'b00;
      pp = ($urandom_range(0, 99) < 40);
      op("rand", pe, pp, $urandom, $urandom, 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
